// File: rtl/sd_pkg.sv
// Shared types and constants for the SD card SPI physical layer.
// SD_SPI_DUAL_SPEED_EN selects between init and data SCK rates.
package sd_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W = 8;
    localparam int BIT_W = 5;

    // Level the card expects on an idle data line.
    localparam logic SD_IDLE_LVL = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_e;

    function automatic logic [CNT_W-1:0] half_pick(
        input logic fast,
        input int unsigned f,
        input int unsigned s
    );
        return fast ? CNT_W'(f) : CNT_W'(s);
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// SCK half-period generator: reloadable down-counter with a
// one-cycle tick at the last clk of every half-period.
module spi_half_tick
    import sd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] half_i,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = half_i - 8'd1;
        end else if (en_i) begin
            cnt_d = (cnt_q == '0) ? half_i - 8'd1 : cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/sd_spi_phy.sv
// SPI mode-0 master for the SD card pins, one 32-bit word per request.
// SD_SPI_DUAL_SPEED_EN adds spd_fast to pick HALF_DIV or HALF_DIV_SLOW.
module sd_spi_phy
    import sd_pkg::*;
#(
    parameter int unsigned HALF_DIV      = 2,
    parameter int unsigned HALF_DIV_SLOW = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] spi_mosi,
    output logic [WORD_W-1:0] spi_miso,
    input  logic              spi_begin,
    input  logic              spi_ready,
    output logic              spi_busy,
    output logic              sd_sck,
    output logic              sd_mosi,
    input  logic              sd_miso,
`ifdef SD_SPI_DUAL_SPEED_EN
    input  logic              spd_fast,
`endif
    output logic              sd_cs_n
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] tx_q, tx_d;
    logic [WORD_W-1:0] rx_q, rx_d;
    logic [WORD_W-1:0] miso_q, miso_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              spd_q, spd_d;
    logic [1:0]        sync_q;
    logic              spd_in;
    logic              load;
    logic              en;
    logic              tick;
    logic [CNT_W-1:0]  half;

`ifdef SD_SPI_DUAL_SPEED_EN
    assign spd_in = spd_fast;
`else
    assign spd_in = 1'b1;
`endif

    // Speed is frozen at transfer start; only IDLE follows the live input.
    assign half = half_pick((state_q == IDLE) ? spd_in : spd_q,
                            HALF_DIV, HALF_DIV_SLOW);
    assign en   = (state_q == LOW) || (state_q == HIGH);

    spi_half_tick u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .en_i   (en),
        .half_i (half),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        miso_d  = miso_q;
        bit_d   = bit_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        busy_d  = busy_q;
        spd_d   = spd_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cs_n_d = ~spi_ready;
                if (spi_begin) begin
                    tx_d    = spi_mosi;
                    mosi_d  = spi_mosi[WORD_W-1];
                    busy_d  = 1'b1;
                    bit_d   = '0;
                    spd_d   = spd_in;
                    load    = 1'b1;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (tick) begin
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[WORD_W-2:0], sync_q[1]};
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (tick) begin
                    sck_d = 1'b0;
                    if (bit_q == BIT_W'(WORD_W - 1)) begin
                        state_d = DONE;
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        tx_d    = tx_q << 1;
                        mosi_d  = tx_q[WORD_W-2];
                        state_d = LOW;
                    end
                end
            end
            DONE: begin
                miso_d  = rx_q;
                busy_d  = 1'b0;
                mosi_d  = SD_IDLE_LVL;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            miso_q  <= '0;
            bit_q   <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= SD_IDLE_LVL;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            spd_q   <= 1'b1;
            sync_q  <= {2{SD_IDLE_LVL}};
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            miso_q  <= miso_d;
            bit_q   <= bit_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            spd_q   <= spd_d;
            sync_q  <= {sync_q[0], sd_miso};
        end
    end

    assign spi_miso = miso_q;
    assign spi_busy = busy_q;
    assign sd_sck   = sck_q;
    assign sd_mosi  = mosi_q;
    assign sd_cs_n  = cs_n_q;

endmodule

// File: tb/tb_sd_spi_phy.sv
// Directed bench for sd_spi_phy at HALF_DIV=4 with optional
// SD_SPI_DUAL_SPEED_EN slow-rate section.
module tb_sd_spi_phy;

    logic        clk;
    logic        rst_n;
    logic [31:0] spi_mosi;
    logic [31:0] spi_miso;
    logic        spi_begin;
    logic        spi_ready;
    logic        spi_busy;
    logic        sd_sck;
    logic        sd_mosi;
    logic        sd_miso;
    logic        sd_cs_n;
    logic        loop;
    logic        force_miso;
`ifdef SD_SPI_DUAL_SPEED_EN
    logic        spd_fast;
`endif

    int total;
    int bad;
    int busy_ctr;
    int rise_ctr;
    int b0;
    int r0;

    // Loopback: the DUT's own synchroniser is the 2-cycle delay.
    assign sd_miso = loop ? sd_mosi : force_miso;

    sd_spi_phy #(
        .HALF_DIV      (4),
        .HALF_DIV_SLOW (128)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .spi_begin (spi_begin),
        .spi_ready (spi_ready),
        .spi_busy  (spi_busy),
        .sd_sck    (sd_sck),
        .sd_mosi   (sd_mosi),
        .sd_miso   (sd_miso),
`ifdef SD_SPI_DUAL_SPEED_EN
        .spd_fast  (spd_fast),
`endif
        .sd_cs_n   (sd_cs_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial busy_ctr = 0;
    always @(negedge clk) if (spi_busy === 1'b1) busy_ctr++;

    initial rise_ctr = 0;
    always @(posedge sd_sck) rise_ctr++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] w);
        @(posedge clk);
        #1;
        spi_mosi  = w;
        spi_begin = 1'b1;
        b0 = busy_ctr;
        r0 = rise_ctr;
        @(posedge clk);
        #1;
        spi_begin = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (spi_busy === 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("busy_timeout", {31'b0, spi_busy}, 32'h0);
    endtask

    initial begin
        int n;
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        spi_mosi   = '0;
        spi_begin  = 1'b0;
        spi_ready  = 1'b0;
        loop       = 1'b1;
        force_miso = 1'b1;
`ifdef SD_SPI_DUAL_SPEED_EN
        spd_fast   = 1'b1;
`endif
        repeat (3) @(negedge clk);
        chk("rst_sck", {31'b0, sd_sck}, 32'h0);
        chk("rst_mosi", {31'b0, sd_mosi}, 32'h1);
        chk("rst_cs_n", {31'b0, sd_cs_n}, 32'h1);
        chk("rst_busy", {31'b0, spi_busy}, 32'h0);
        chk("rst_miso", spi_miso, 32'h0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        spi_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_cs_n", {31'b0, sd_cs_n}, 32'h0);

        // Loopback word
        start(32'hA5C3_0F81);
        repeat (20) @(negedge clk);
        chk("t1_busy_mid", {31'b0, spi_busy}, 32'h1);
        wait_done(400);
        chk("t1_miso", spi_miso, 32'hA5C3_0F81);
        chk("t1_busy_cyc", busy_ctr - b0, 32'd257);
        chk("t1_rises", rise_ctr - r0, 32'd32);
        chk("t1_mosi_idle", {31'b0, sd_mosi}, 32'h1);

        // Card drives all ones, send zeros
        loop = 1'b0;
        start(32'h0000_0000);
        repeat (20) @(negedge clk);
        chk("t2_mosi_mid", {31'b0, sd_mosi}, 32'h0);
        wait_done(400);
        chk("t2_miso", spi_miso, 32'hFFFF_FFFF);
        chk("t2_mosi_idle", {31'b0, sd_mosi}, 32'h1);
        loop = 1'b1;

        // Second begin during a transfer is dropped
        start(32'h3C96_E10F);
        repeat (8) @(posedge clk);
        #1;
        spi_mosi  = 32'h0000_0000;
        spi_begin = 1'b1;
        @(posedge clk);
        #1;
        spi_begin = 1'b0;
        wait_done(400);
        chk("t3_miso", spi_miso, 32'h3C96_E10F);
        chk("t3_rises", rise_ctr - r0, 32'd32);
        chk("t3_busy_cyc", busy_ctr - b0, 32'd257);
        repeat (5) @(negedge clk);
        chk("t3_no_queue", {31'b0, spi_busy}, 32'h0);
        chk("t3_miso_hold", spi_miso, 32'h3C96_E10F);

        // spi_ready drops at bit 8
        start(32'h1357_9BDF);
        repeat (64) @(posedge clk);
        #1;
        spi_ready = 1'b0;
        @(negedge clk);
        chk("t4_cs_held", {31'b0, sd_cs_n}, 32'h0);
        wait_done(400);
        chk("t4_cs_first_idle", {31'b0, sd_cs_n}, 32'h0);
        @(negedge clk);
        chk("t4_cs_after", {31'b0, sd_cs_n}, 32'h1);
        chk("t4_miso", spi_miso, 32'h1357_9BDF);

        // Dummy clocks with card deselected
        start(32'h0F0F_F0F0);
        repeat (30) @(negedge clk);
        chk("t4b_cs_n", {31'b0, sd_cs_n}, 32'h1);
        wait_done(400);
        chk("t4b_rises", rise_ctr - r0, 32'd32);
        chk("t4b_miso", spi_miso, 32'h0F0F_F0F0);

        // Reset during bit 16 while SCK is high
        spi_ready = 1'b1;
        repeat (3) @(negedge clk);
        start(32'hDEAD_BEEF);
        n = 0;
        while ((rise_ctr - r0) < 17 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t5_pre_sck", {31'b0, sd_sck}, 32'h1);
        chk("t5_pre_cs_n", {31'b0, sd_cs_n}, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_sck", {31'b0, sd_sck}, 32'h0);
        chk("t5_cs_n", {31'b0, sd_cs_n}, 32'h1);
        chk("t5_busy", {31'b0, spi_busy}, 32'h0);
        chk("t5_miso", spi_miso, 32'h0);
        chk("t5_mosi", {31'b0, sd_mosi}, 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start(32'h8000_0001);
        wait_done(400);
        chk("t5_after_miso", spi_miso, 32'h8000_0001);
        chk("t5_after_rises", rise_ctr - r0, 32'd32);
        chk("t5_after_busy", busy_ctr - b0, 32'd257);

`ifdef SD_SPI_DUAL_SPEED_EN
        spd_fast = 1'b0;
        start(32'h5A5A_1234);
        wait_done(9000);
        chk("ds_slow_busy", busy_ctr - b0, 32'd8193);
        chk("ds_slow_miso", spi_miso, 32'h5A5A_1234);
        spd_fast = 1'b1;
        start(32'hC001_D00D);
        repeat (20) @(posedge clk);
        #1;
        spd_fast = 1'b0;
        wait_done(400);
        chk("ds_fast_busy", busy_ctr - b0, 32'd257);
        chk("ds_fast_miso", spi_miso, 32'hC001_D00D);
        spd_fast = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
